matmul2x2_mul_sequencer: RTL and testbench

- Sequences a single shared 4x4 pipelined multiplier (do/done handshake, result registered at done) to compute a 2x2 by 2x2 matrix product C = A x B of unsigned W-bit elements.
- Issues the 8 element products one at a time, accumulates them into 9-bit sums, and presents the packed C with a done pulse.
- Sits between the matrix-multiply top level and the multiplier instance.

---
 rtl/matmul2x2_mul_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_matmul2x2_mul_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul2x2_mul_sequencer.sv
// matmul2x2_mul_sequencer
//   Computes C = A x B for 2x2 matrices of unsigned W-bit elements. It uses one
//   shared pipelined multiplier with a do/done handshake. The eight element
//   products are issued one after another and summed in pairs into 2W+1 bit
//   elements. The packed C is presented together with a one-cycle done pulse.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   start            operation request, accepted only while idle
//   a_mat, b_mat     packed operands, element index {row,col}: [W-1:0]=x00 ... [4W-1:3W]=x11
//   busy             high from the cycle after accept through the done cycle
//   done, err        completion pulse; err flags a multiplier timeout (valid with done,
//                    held until the next accept)
//   c_mat            packed result, 2W+1 bits per element, same element order
//   mul_a, mul_b     multiplier operands (zero while idle)
//   mul_do           multiplier request
//   mul_result       multiplier product, registered by the multiplier at mul_done
//   mul_done         multiplier completion
module matmul2x2_mul_sequencer #(
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*W-1:0]         a_mat,
  input  logic [4*W-1:0]         b_mat,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [4*(2*W+1)-1:0]   c_mat,
  output logic [W-1:0]           mul_a,
  output logic [W-1:0]           mul_b,
  output logic                   mul_do,
  input  logic [2*W-1:0]         mul_result,
  input  logic                   mul_done
);

  localparam int CW = 2*W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0][W-1:0]      a_q, a_d;
  logic [3:0][W-1:0]      b_q, b_d;
  logic [CW-1:0]          acc_q, acc_d;
  logic [3:0][CW-1:0]     shadow_q, shadow_d;
  logic [3:0][CW-1:0]     c_q, c_d;
  logic                   err_q, err_d;
  logic [2:0]             p_q, p_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  // Product p decodes as i=p[2], j=p[1], k=p[0]; A[i][k] sits at element
  // {i,k}, B[k][j] at element {k,j}, and the sum lands in C element {i,j}.
  logic [1:0]    a_idx, b_idx, c_idx;
  logic          k_last;
  logic          tmo_hit;
  logic [CW-1:0] acc_sum;

  assign a_idx   = {p_q[2], p_q[0]};
  assign b_idx   = {p_q[0], p_q[1]};
  assign c_idx   = {p_q[2], p_q[1]};
  assign k_last  = p_q[0];
  // WAIT and DRAIN share one per-product budget; this is its last cycle.
  assign tmo_hit = (tmo_q + TW'(1)) == TW'(TIMEOUT);
  assign acc_sum = acc_q + CW'(mul_result);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      err_q    <= 1'b0;
      p_q      <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      err_q    <= err_d;
      p_q      <= p_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (mul_done)     state_d = S_DRAIN;
        else if (tmo_hit) state_d = S_FINISH;
      end
      S_DRAIN: begin
        // Wait for the previous done to fall so it cannot be mistaken
        // for the completion of the next product.
        if (!mul_done)    state_d = (p_q == 3'd7) ? S_FINISH : S_ISSUE;
        else if (tmo_hit) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    err_d    = err_q;
    p_d      = p_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a_mat;
          b_d      = b_mat;
          acc_d    = '0;
          shadow_d = '0;
          err_d    = 1'b0;
          p_d      = '0;
        end
      end
      S_ISSUE: tmo_d = '0;
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (mul_done) begin
          if (k_last) begin
            shadow_d[c_idx] = acc_sum;
            acc_d           = '0;
          end else begin
            acc_d = acc_sum;
          end
        end else if (tmo_hit) begin
          err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        tmo_d = tmo_q + TW'(1);
        if (!mul_done) begin
          // Publish on the way into FINISH so c_mat is valid with done.
          if (p_q == 3'd7) c_d = shadow_q;
          else             p_d = p_q + 3'd1;
        end else if (tmo_hit) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_FINISH);
    mul_do = (state_q == S_ISSUE) || (state_q == S_WAIT);
    mul_a  = '0;
    mul_b  = '0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN)) begin
      mul_a = a_q[a_idx];
      mul_b = b_q[b_idx];
    end
  end

  assign err   = err_q;
  assign c_mat = c_q;

endmodule

// File: tb/tb_matmul2x2_mul_sequencer.sv
module tb_matmul2x2_mul_sequencer;
  localparam int W       = 4;
  localparam int TIMEOUT = 64;
  localparam int CW      = 2*W + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [4*W-1:0]    a_mat = '0;
  logic [4*W-1:0]    b_mat = '0;
  logic              busy, done, err, mul_do;
  logic [4*CW-1:0]   c_mat;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_result;
  logic              mul_done;

  always #5 clk = ~clk;

  matmul2x2_mul_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .a_mat(a_mat), .b_mat(b_mat),
    .busy(busy), .done(done), .err(err), .c_mat(c_mat),
    .mul_a(mul_a), .mul_b(mul_b), .mul_do(mul_do),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Multiplier model: done rises lat cycles after do is seen, result registered
  // with it; done falls dly cycles after do drops. dead suppresses done.
  int lat = 0, dly = 1;
  bit dead = 1'b0;
  int mcnt = 0, dcnt = 0;
  always @(posedge clk) begin
    if (reset || dead) begin
      mul_done <= 1'b0; mcnt <= 0; dcnt <= 0;
      if (reset) mul_result <= '0;
    end else if (mul_do) begin
      dcnt <= 0;
      if (!mul_done) begin
        if (mcnt >= lat) begin
          mul_done   <= 1'b1;
          mul_result <= 8'(mul_a) * 8'(mul_b);
          mcnt       <= 0;
        end else mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
      if (mul_done) begin
        if (dcnt >= dly - 1) begin mul_done <= 1'b0; dcnt <= 0; end
        else dcnt <= dcnt + 1;
      end
    end
  end

  // Scoreboard queues
  logic [4*CW-1:0] exp_c_q[$];
  bit              exp_err_q[$];
  int              exp_np_q[$];
  logic [2*W-1:0]  exp_ops_q[$];
  logic [4*CW-1:0] last_good_c = '0;

  int  npulse = 0;
  int  done_cnt = 0;
  logic do_prev = 1'b0;
  logic [4*CW-1:0] c_prev = '0;

  always @(negedge clk) begin
    logic [2*W-1:0] op;
    if (!reset) begin
      if (mul_do && !do_prev) begin
        npulse++;
        chk("op_queue", exp_ops_q.size() > 0, 1);
        if (exp_ops_q.size() > 0) begin
          op = exp_ops_q.pop_front();
          chk("mul_a", mul_a, op[2*W-1:W]);
          chk("mul_b", mul_b, op[W-1:0]);
        end
      end
      if (done) begin
        chk("done_expected", exp_c_q.size() > 0, 1);
        chk("do_in_finish", mul_do, 0);
        chk("busy_in_finish", busy, 1);
        if (exp_c_q.size() > 0) begin
          chk("c_mat", c_mat, exp_c_q.pop_front());
          chk("err", err, exp_err_q.pop_front());
          chk("do_pulses", npulse, exp_np_q.pop_front());
        end
        $display("done #%0d c_mat=%0h err=%0b pulses=%0d", done_cnt + 1, c_mat, err, npulse);
        npulse = 0;
        done_cnt++;
      end
      if (c_mat !== c_prev) chk("c_stable", done && !err, 1);
    end
    do_prev = mul_do;
    c_prev  = c_mat;
  end

  function automatic logic [4*CW-1:0] matmul(input logic [15:0] a, input logic [15:0] b);
    logic [4*CW-1:0] c;
    int ai, bi;
    c = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        logic [CW-1:0] s;
        s = '0;
        for (int k = 0; k < 2; k++) begin
          ai = 2*i + k;
          bi = 2*k + j;
          s += CW'(a[ai*W +: W]) * CW'(b[bi*W +: W]);
        end
        c[(2*i+j)*CW +: CW] = s;
      end
    return c;
  endfunction

  // Issue order as element indices: a00b00 a01b10 a00b01 a01b11 a10b00 a11b10 a10b01 a11b11
  int a_ord[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
  int b_ord[8] = '{0, 2, 1, 3, 0, 2, 1, 3};

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit timeout_exp);
    int np;
    np = timeout_exp ? 1 : 8;
    for (int p = 0; p < np; p++)
      exp_ops_q.push_back({a[a_ord[p]*W +: W], b[b_ord[p]*W +: W]});
    if (!timeout_exp) last_good_c = matmul(a, b);
    exp_c_q.push_back(last_good_c);
    exp_err_q.push_back(timeout_exp);
    exp_np_q.push_back(np);
    chk("busy_idle", busy, 0);
    a_mat = a; b_mat = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    $display("start a=%h b=%h lat=%0d dly=%0d dead=%0b", a, b, lat, dly, dead);
  endtask

  task automatic wait_done(input int budget);
    int target;
    target = done_cnt + 1;
    for (int n = 0; n < budget && done_cnt < target; n++) @(posedge clk);
    #2;
    chk("done_wait", done_cnt, target);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    exp_c_q.delete(); exp_err_q.delete(); exp_np_q.delete(); exp_ops_q.delete();
    last_good_c = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_c", c_mat, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_do", mul_do, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    npulse = 0;
    $display("reset applied");
  endtask

  initial begin
    int d0;
    do_reset();

    // Example product, multiplier done already high on entry to WAIT
    lat = 0; dly = 1;
    start_op(16'h4321, 16'h8765, 1'b0);
    wait_done(400);
    chk("c_example", c_mat, {9'd50, 9'd43, 9'd22, 9'd19});

    // Maximum elements
    lat = 2; dly = 2;
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done(400);
    chk("c_max", c_mat, {4{9'h1C2}});

    // Identity then zero, idle gap between
    lat = 1; dly = 1;
    start_op(16'h1001, 16'hCBA9, 1'b0);
    wait_done(400);
    chk("c_identity", c_mat, {9'd12, 9'd11, 9'd10, 9'd9});
    repeat (10) @(posedge clk);
    #2;
    chk("c_hold_idle", c_mat, {9'd12, 9'd11, 9'd10, 9'd9});
    start_op(16'h0000, 16'hCBA9, 1'b0);
    wait_done(400);
    chk("c_zero", c_mat, 0);

    // Start while busy is ignored
    lat = 3; dly = 1;
    d0 = done_cnt;
    start_op(16'h4321, 16'h8765, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    a_mat = 16'hFFFF; b_mat = 16'hFFFF; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(400);
    repeat (100) @(posedge clk);
    #2;
    chk("single_done", done_cnt - d0, 1);

    // Multiplier never answers: timeout, c_mat kept, then recovery
    dead = 1'b1;
    start_op(16'h1111, 16'h2222, 1'b1);
    wait_done(TIMEOUT + 40);
    chk("err_held", err, 1);
    chk("c_kept", c_mat, {9'd50, 9'd43, 9'd22, 9'd19});
    dead = 1'b0;
    lat = 1; dly = 2;
    start_op(16'h2143, 16'h1234, 1'b0);
    @(negedge clk);
    chk("err_cleared", err, 0);
    wait_done(400);

    // Reset during product 4 aborts, then a fresh operation
    start_op(16'h1001, 16'h8765, 1'b0);
    for (int n = 0; n < 400 && npulse < 5; n++) @(posedge clk);
    chk("reached_p4", npulse, 5);
    d0 = done_cnt;
    do_reset();
    repeat (5) @(posedge clk);
    #2;
    chk("no_done_after_abort", done_cnt, d0);
    start_op(16'h4321, 16'hFFFF, 1'b0);
    wait_done(400);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
